// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: opcodes, FSM encoding,
// memory-op decode and the byte-lane extend helper.
package mem_access_stage_pkg;

    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_SB  = 6'h28;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    typedef struct packed {
        logic is_load;
        logic is_store;
        logic is_byte;
        logic sign_ext;
    } mem_op_t;

    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t op;
        op = '0;
        case (opcode)
            OP_LW:  op.is_load = 1'b1;
            OP_LB:  begin op.is_load = 1'b1; op.is_byte = 1'b1; op.sign_ext = 1'b1; end
            OP_LBU: begin op.is_load = 1'b1; op.is_byte = 1'b1; end
            OP_SW:  op.is_store = 1'b1;
            OP_SB:  begin op.is_store = 1'b1; op.is_byte = 1'b1; end
            default: ;
        endcase
        return op;
    endfunction

    // Little-endian lane select: lane 0 is bits 7:0.
    function automatic logic [31:0] lane_extend(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic        is_byte,
                                                input logic        sign_ext);
        logic [7:0] b;
        b = word[{lane, 3'b000} +: 8];
        if (!is_byte) return word;
        return sign_ext ? {{24{b[7]}}, b} : {24'h0, b};
    endfunction

endpackage

// File: rtl/mem_data_ram.sv
// Word-organised data RAM: one byte-enabled synchronous write port, a
// combinational access read port and a combinational debug read port.
module mem_data_ram #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_data
);

    logic [31:0] mem [DEPTH];

    // NOTE: the array has no reset; clearing it would need DEPTH cycles or
    // a huge reset fan-out, and its contents are deliberately preserved.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata     = mem[addr];
    assign disp_data = mem[disp_addr];

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: decodes loads/stores from EX/MEM, runs them against the data RAM
// with programmable wait states, and registers the MEM/WB results.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [31:0]       in_inst,
    input  logic [31:0]       in_alu_out,
    input  logic [31:0]       in_store_data,
    output logic              stall,
    output logic              out_valid,
    output logic [31:0]       out_inst,
    output logic [31:0]       out_alu,
    output logic [31:0]       out_lmd,
    output logic              out_misalign,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [31:0]       disp_data
);

    localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [31:0] cap_inst;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;
    logic        busy;

    logic [5:0]        act_opcode;
    logic [ADDR_W+1:0] act_addr;
    logic [31:0]       act_data;
    mem_op_t           op;
    logic              misalign;
    logic              mem_ok;
    logic              finish;

    logic              ram_we;
    logic [3:0]        ram_be;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic [31:0]       load_val;

    assign busy  = (state == ST_BUSY);
    assign stall = busy;

    // While busy the captured op owns the RAM port and in_* are ignored.
    // NOTE: every signal written here gets a value on every path, so no
    // latch can be inferred.
    always_comb begin
        act_opcode = in_inst[31:26];
        act_addr   = in_alu_out[ADDR_W+1:0];
        act_data   = in_store_data;
        if (busy) begin
            act_opcode = cap_inst[31:26];
            act_addr   = cap_addr[ADDR_W+1:0];
            act_data   = cap_data;
        end
    end

    assign op       = decode_op(act_opcode);
    assign misalign = (op.is_load || op.is_store) && !op.is_byte && (act_addr[1:0] != 2'b00);
    assign mem_ok   = (op.is_load || op.is_store) && !misalign;
    assign finish   = busy ? (cnt == 4'd0) : (in_valid && mem_ok && (WAIT_STATES == 0));

    assign ram_we    = finish && op.is_store;
    assign ram_be    = op.is_byte ? (4'b0001 << act_addr[1:0]) : 4'b1111;
    assign ram_wdata = op.is_byte ? {4{act_data[7:0]}} : act_data;
    assign load_val  = lane_extend(ram_rdata, act_addr[1:0], op.is_byte, op.sign_ext);

    mem_data_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clock     (clock),
        .we        (ram_we),
        .be        (ram_be),
        .addr      (act_addr[ADDR_W+1:2]),
        .wdata     (ram_wdata),
        .rdata     (ram_rdata),
        .disp_addr (disp_addr),
        .disp_data (disp_data)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            cap_inst     <= '0;
            cap_addr     <= '0;
            cap_data     <= '0;
            out_valid    <= 1'b0;
            out_inst     <= '0;
            out_alu      <= '0;
            out_lmd      <= '0;
            out_misalign <= 1'b0;
        end else if (busy) begin
            if (cnt != 4'd0) begin
                cnt       <= cnt - 4'd1;
                out_valid <= 1'b0;
            end else begin
                state        <= ST_IDLE;
                out_valid    <= 1'b1;
                out_inst     <= cap_inst;
                out_alu      <= cap_addr;
                out_lmd      <= op.is_load ? load_val : 32'h0;
                out_misalign <= 1'b0;
            end
        end else if (!in_valid) begin
            out_valid <= 1'b0;
        end else if (!mem_ok || (WAIT_STATES == 0)) begin
            out_valid    <= 1'b1;
            out_inst     <= in_inst;
            out_alu      <= in_alu_out;
            out_lmd      <= (mem_ok && op.is_load) ? load_val : 32'h0;
            out_misalign <= misalign;
        end else begin
            state     <= ST_BUSY;
            cnt       <= CNT_INIT;
            cap_inst  <= in_inst;
            cap_addr  <= in_alu_out;
            cap_data  <= in_store_data;
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: a WAIT_STATES=2 instance driven by directed and
// random ops against a word-array model, and a WAIT_STATES=0 instance driven
// back-to-back from a vector table.
module tb_mem_access_stage;
    import mem_access_stage_pkg::*;

    localparam int W_A = 2;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        a_valid, a_stall, a_ovalid, a_omis;
    logic [31:0] a_inst, a_alu, a_sdata, a_oinst, a_oalu, a_olmd, a_disp;
    logic [7:0]  a_disp_addr;
    logic        b_valid, b_stall, b_ovalid, b_omis;
    logic [31:0] b_inst, b_alu, b_sdata, b_oinst, b_oalu, b_olmd, b_disp;
    logic [7:0]  b_disp_addr;

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(W_A)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_valid), .in_inst(a_inst),
        .in_alu_out(a_alu), .in_store_data(a_sdata), .stall(a_stall),
        .out_valid(a_ovalid), .out_inst(a_oinst), .out_alu(a_oalu),
        .out_lmd(a_olmd), .out_misalign(a_omis), .disp_addr(a_disp_addr),
        .disp_data(a_disp)
    );

    mem_access_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_STATES(0)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_valid), .in_inst(b_inst),
        .in_alu_out(b_alu), .in_store_data(b_sdata), .stall(b_stall),
        .out_valid(b_ovalid), .out_inst(b_oinst), .out_alu(b_oalu),
        .out_lmd(b_olmd), .out_misalign(b_omis), .disp_addr(b_disp_addr),
        .disp_data(b_disp)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] ref_mem [256];

    typedef struct packed {
        logic        vld;
        logic [31:0] inst;
        logic [31:0] alu;
        logic [31:0] sd;
        logic [31:0] lmd;
        logic        mis;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] opc);
        return {opc, 26'h0123456};
    endfunction

    // Aligned stores leave out_lmd unspecified, so it is not compared for them.
    function automatic bit lmd_defined(input logic [31:0] inst, input logic [31:0] alu);
        logic [5:0] opc;
        opc = inst[31:26];
        return !((opc == OP_SB) || (opc == OP_SW && alu[1:0] == 2'b00));
    endfunction

    // Reference behaviour: word array, byte ops by shift/mask arithmetic.
    task automatic model_op(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] sd,
                            output logic [31:0] lmd, output logic mis, output int lat);
        int unsigned idx;
        int unsigned sh;
        logic [31:0] b;
        logic [5:0]  opc;
        idx = (alu >> 2) % 256;
        sh  = 8 * alu[1:0];
        opc = inst[31:26];
        lmd = 32'h0;
        mis = 1'b0;
        lat = 1;
        case (opc)
            OP_LW: if (alu[1:0] != 0) mis = 1'b1;
                   else begin lmd = ref_mem[idx]; lat = W_A + 1; end
            OP_LB, OP_LBU: begin
                b = (ref_mem[idx] >> sh) & 32'hFF;
                if (opc == OP_LB && b >= 128) b = b - 256;
                lmd = b;
                lat = W_A + 1;
            end
            OP_SW: if (alu[1:0] != 0) mis = 1'b1;
                   else begin ref_mem[idx] = sd; lat = W_A + 1; end
            OP_SB: begin
                ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((sd & 32'hFF) << sh);
                lat = W_A + 1;
            end
            default: ;
        endcase
    endtask

    // Issue one op on instance A from a negedge; garbage is driven while stalled.
    task automatic run_a(input string tag, input logic [31:0] inst, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [31:0] exp_lmd, input logic exp_mis,
                         input int exp_lat);
        int lat;
        int stalls;
        logic [31:0] junk;
        a_valid = 1'b1; a_inst = inst; a_alu = alu; a_sdata = sd;
        lat = 0;
        stalls = 0;
        do begin
            @(posedge clock); @(negedge clock);
            lat++;
            if (!a_ovalid) begin
                if (a_stall) stalls++;
                junk = $urandom();
                a_inst  = {OP_SW, junk[25:0]};
                a_alu   = $urandom();
                a_sdata = $urandom();
            end
        end while (!a_ovalid && lat < 40);
        a_valid = 1'b0;
        check({tag, " out_valid"}, a_ovalid, 1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " stall cycles"}, stalls, exp_lat - 1);
        check({tag, " stall after"}, a_stall, 0);
        check({tag, " out_inst"}, a_oinst, inst);
        check({tag, " out_alu"}, a_oalu, alu);
        check({tag, " out_misalign"}, a_omis, exp_mis);
        if (lmd_defined(inst, alu)) check({tag, " out_lmd"}, a_olmd, exp_lmd);
        @(posedge clock); @(negedge clock);
        check({tag, " single pulse"}, a_ovalid, 0);
    endtask

    task automatic model_run_a(input string tag, input logic [31:0] inst,
                               input logic [31:0] alu, input logic [31:0] sd);
        logic [31:0] lmd;
        logic        mis;
        int          lat;
        model_op(inst, alu, sd, lmd, mis, lat);
        run_a(tag, inst, alu, sd, lmd, mis, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r;
        logic [5:0]  opc;
        int          kind;
        int          w;
        int          lane;

        reset = 1'b0;
        a_valid = 0; a_inst = 0; a_alu = 0; a_sdata = 0; a_disp_addr = 0;
        b_valid = 0; b_inst = 0; b_alu = 0; b_sdata = 0; b_disp_addr = 0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst a stall", a_stall, 0);
        check("rst a out_valid", a_ovalid, 0);
        check("rst a out_inst", a_oinst, 0);
        check("rst a out_alu", a_oalu, 0);
        check("rst a out_lmd", a_olmd, 0);
        check("rst a out_misalign", a_omis, 0);
        check("rst b out_valid", b_ovalid, 0);
        check("rst b stall", b_stall, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); @(negedge clock);
            check("bubble a out_valid", a_ovalid, 0);
            check("bubble a stall", a_stall, 0);
            check("bubble b out_valid", b_ovalid, 0);
        end

        // Wait-state store/load
        run_a("sw 0x10", mk(OP_SW), 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
        a_disp_addr = 8'd4;
        #1 check("disp word4 after sw", a_disp, 32'hDEADBEEF);
        run_a("lw 0x10", mk(OP_LW), 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

        // Byte store read-modify-write and byte loads
        run_a("sb 0x13", mk(OP_SB), 32'h13, 32'h77665580, 32'h0, 1'b0, 3);
        run_a("lb 0x13", mk(OP_LB), 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 3);
        run_a("lbu 0x13", mk(OP_LBU), 32'h13, 32'h0, 32'h00000080, 1'b0, 3);
        run_a("lw 0x10 rmw", mk(OP_LW), 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);

        // Misaligned word access and non-memory op
        run_a("lw 0x06 misalign", mk(OP_LW), 32'h06, 32'h0, 32'h0, 1'b1, 1);
        run_a("add", mk(6'h00), 32'h1234, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
        run_a("lw 0x10 after", mk(OP_LW), 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 3);

        // Zero-wait instance: a write and display read of the same word
        b_disp_addr = 8'd9;
        b_valid = 1'b1; b_inst = mk(OP_SW); b_alu = 32'h24; b_sdata = 32'h0BADCAFE;
        @(posedge clock); @(negedge clock);
        b_sdata = 32'h600DF00D;
        #1 check("b disp old before edge", b_disp, 32'h0BADCAFE);
        @(posedge clock); #1;
        check("b disp new after edge", b_disp, 32'h600DF00D);
        @(negedge clock);

        tbl[0]  = '{1'b1, mk(OP_SW),  32'h400, 32'h11223344, 32'h0,        1'b0};
        tbl[1]  = '{1'b1, mk(OP_LW),  32'h000, 32'h0,        32'h11223344, 1'b0};
        tbl[2]  = '{1'b1, mk(6'h00),  32'h1234, 32'h0,       32'h0,        1'b0};
        tbl[3]  = '{1'b1, mk(OP_SB),  32'h001, 32'hFFFFFFAB, 32'h0,        1'b0};
        tbl[4]  = '{1'b1, mk(OP_LBU), 32'h401, 32'h0,        32'h000000AB, 1'b0};
        tbl[5]  = '{1'b1, mk(OP_LB),  32'h001, 32'h0,        32'hFFFFFFAB, 1'b0};
        tbl[6]  = '{1'b1, mk(OP_LW),  32'h000, 32'h0,        32'h1122AB44, 1'b0};
        tbl[7]  = '{1'b0, mk(OP_SW),  32'h000, 32'hBAD0BAD0, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, mk(OP_LW),  32'h006, 32'h0,        32'h0,        1'b1};
        tbl[9]  = '{1'b1, mk(OP_SW),  32'h002, 32'h99999999, 32'h0,        1'b1};
        tbl[10] = '{1'b1, mk(OP_LW),  32'h000, 32'h0,        32'h1122AB44, 1'b0};
        tbl[11] = '{1'b1, mk(OP_SW),  32'h008, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[12] = '{1'b1, mk(OP_LB),  32'h00B, 32'h0,        32'hFFFFFFCA, 1'b0};
        tbl[13] = '{1'b1, mk(OP_LBU), 32'h008, 32'h0,        32'h0000000D, 1'b0};
        tbl[14] = '{1'b1, mk(OP_LW),  32'h408, 32'h0,        32'hCAFEF00D, 1'b0};
        tbl[15] = '{1'b1, mk(OP_LW),  32'h024, 32'h0,        32'h600DF00D, 1'b0};

        for (int i = 0; i < 16; i++) begin
            b_valid = tbl[i].vld; b_inst = tbl[i].inst; b_alu = tbl[i].alu; b_sdata = tbl[i].sd;
            @(posedge clock); @(negedge clock);
            check($sformatf("b[%0d] stall", i), b_stall, 0);
            check($sformatf("b[%0d] out_valid", i), b_ovalid, tbl[i].vld);
            if (tbl[i].vld) begin
                check($sformatf("b[%0d] out_inst", i), b_oinst, tbl[i].inst);
                check($sformatf("b[%0d] out_alu", i), b_oalu, tbl[i].alu);
                check($sformatf("b[%0d] out_misalign", i), b_omis, tbl[i].mis);
                if (lmd_defined(tbl[i].inst, tbl[i].alu))
                    check($sformatf("b[%0d] out_lmd", i), b_olmd, tbl[i].lmd);
            end
        end
        b_valid = 1'b0;
        b_disp_addr = 8'd0;
        #1 check("b disp word0", b_disp, 32'h1122AB44);

        // Preload model region (words 0..31) on instance A
        for (int i = 0; i < 32; i++) begin
            model_run_a($sformatf("preload w%0d", i), mk(OP_SW), 32'(i * 4), $urandom());
        end

        // Reset while busy on a store
        a_valid = 1'b1; a_inst = mk(OP_SW); a_alu = 32'h20; a_sdata = 32'h55;
        @(posedge clock); #1;
        a_valid = 1'b0;
        check("busy stall", a_stall, 1);
        #2 reset = 1'b0;
        #1 check("reset busy stall drop", a_stall, 0);
        check("reset busy out_valid", a_ovalid, 0);
        a_disp_addr = 8'd8;
        #1 check("reset busy disp old", a_disp, ref_mem[8]);
        @(negedge clock); @(negedge clock);
        reset = 1'b1;
        @(posedge clock); @(negedge clock);
        check("after abort disp old", a_disp, ref_mem[8]);
        check("after abort out_valid", a_ovalid, 0);
        check("after abort stall", a_stall, 0);

        // Randomized ops against the model
        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 8);
            w    = $urandom_range(0, 31);
            lane = $urandom_range(0, 3);
            r    = ($urandom() & 32'hFFFF_FC00) | 32'(w << 2);
            case (kind)
                0: model_run_a("rnd lw",  mk(OP_LW),  r, $urandom());
                1: model_run_a("rnd lb",  mk(OP_LB),  r | 32'(lane), $urandom());
                2: model_run_a("rnd lbu", mk(OP_LBU), r | 32'(lane), $urandom());
                3: model_run_a("rnd sw",  mk(OP_SW),  r, $urandom());
                4: model_run_a("rnd sb",  mk(OP_SB),  r | 32'(lane), $urandom());
                5: model_run_a("rnd add", mk(6'h00),  $urandom(), $urandom());
                6: begin
                    opc = 6'($urandom_range(0, 63));
                    model_run_a("rnd opc", mk(opc), r | 32'(lane), $urandom());
                end
                7: begin
                    a_valid = 1'b0; a_inst = mk(OP_SW); a_alu = r;
                    @(posedge clock); @(negedge clock);
                    check("rnd bubble out_valid", a_ovalid, 0);
                    check("rnd bubble stall", a_stall, 0);
                end
                default: model_run_a("rnd misalign", mk(lane[0] ? OP_LW : OP_SW),
                                     r | 32'($urandom_range(1, 3)), $urandom());
            endcase
        end

        for (int i = 0; i < 32; i++) begin
            a_disp_addr = 8'(i);
            #1 check($sformatf("final disp w%0d", i), a_disp, ref_mem[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the five-stage pipeline. Consumes the EX/MEM pipeline-register outputs (instruction, ALU result, store data) and performs loads and stores against an internal word-organised data RAM.
- The RAM has programmable wait states. The stage raises `stall` to freeze the upstream stages while an access is in flight.
- Results are registered toward MEM/WB: load data (LMD), passthrough ALU result, instruction, and a valid bit.
- Also provides a debug read port for the board display, in the same manner as the register-file display port.

Parameters:
- DEPTH, 256, number of 32-bit data words (power of two).
- ADDR_W, 8, log2(DEPTH); word index = alu_out[ADDR_W+1:2].
- WAIT_STATES, 2, extra busy cycles per load/store (0..15).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
- in_inst  in  32  instruction word from EX/MEM
- in_alu_out  in  32  ALU result; the effective address for memory ops
- in_store_data  in  32  rt data for stores
- stall  out  1  hold IF/ID/EX and the EX/MEM register this cycle
- out_valid  out  1  MEM/WB contents valid this cycle
- out_inst  out  32  instruction passed to WB
- out_alu  out  32  ALU result passed to WB
- out_lmd  out  32  load memory data (zero- or sign-extended)
- out_misalign  out  1  misaligned access flagged for this instruction
- disp_addr  in  ADDR_W  debug word index
- disp_data  out  32  combinational RAM[disp_addr]

Behaviour:
- Decode on in_inst[31:26]:
  - LW 0x23, LB 0x20, LBU 0x24: loads.
  - SW 0x2B, SB 0x28: stores.
  - All other opcodes: non-mem.
- Reset (reset=0, async):
  - state=IDLE, cnt=0, stall=0.
  - out_valid=0; out_inst, out_alu and out_lmd = 0; out_misalign=0.
  - RAM contents are not cleared.
- FSM states IDLE, BUSY. `stall` is a registered-state decode: stall = (state==BUSY).
- IDLE, in_valid=0:
  - Next cycle out_valid=0.
  - The other out_* registers hold their values.
- IDLE, non-mem, or misaligned word op (LW/SW with in_alu_out[1:0]≠0):
  - Next edge: out_valid=1; out_inst and out_alu are captured.
  - out_lmd=0.
  - out_misalign=1 only in the misaligned case. No RAM write occurs.
  - Latency is 1 cycle, with no stall.
- IDLE, valid aligned mem op, WAIT_STATES=0:
  - Completes like a non-mem op in 1 cycle.
  - A store writes RAM at that edge; a load captures LMD at that edge.
- IDLE, valid aligned mem op, WAIT_STATES>0:
  - Capture inst, address and store data into internal regs.
  - state→BUSY, cnt=WAIT_STATES-1, out_valid=0 next cycle.
- BUSY:
  - stall=1 and all in_* are ignored. Upstream holds the next instruction in EX/MEM.
  - If cnt≠0: cnt decrements and out_valid=0.
  - If cnt==0: complete the access at this edge (store write / load read into out_lmd). Set out_valid=1 and state→IDLE, so stall drops the following cycle.
- Total load/store latency: acceptance edge to out_valid = WAIT_STATES+1 cycles, with stall high for exactly WAIT_STATES cycles.
- Loads:
  - LW: word read.
  - LB: selected byte (addr[1:0]=0 selects bits 7:0, little-endian), sign-extended.
  - LBU: selected byte, zero-extended.
- Stores:
  - SW: full word write.
  - SB: read-modify-write of the selected byte lane only; the other lanes are unchanged.
- Address bits above ADDR_W+1 are ignored, so addresses wrap modulo DEPTH words.
- Store followed by load to the same address: the load sees the new data, because the write completes before the next acceptance.
- disp_data is combinational. If a write and a display read of the same word fall in the same cycle, disp_data shows the old value until the edge.
- Reset during BUSY: the op is aborted and stall drops immediately. A pending store is not written.
- out_valid pulses exactly once per accepted valid instruction. Bubbles never produce out_valid.

Decomposition:
- Shared package holds:
  - Opcode constants OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB.
  - The FSM state encoding.
  - The byte-lane extend helper function.
- One sub-module: mem_data_ram.
  - DEPTH×32 array.
  - One synchronous write port with 4-bit byte enable.
  - One combinational read port for the access.
  - One combinational debug read port.
- The FSM, decode and output registers stay in mem_access_stage.

Test Plan:
1. Reset held low, then released → all out_*=0, stall=0. Bubbles (in_valid=0) → out_valid stays 0.
2. W=2: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 → stall high 2 cycles per op; LW out_lmd=0xDEADBEEF 3 cycles after acceptance.
3. SB addr 0x13 data 0x80, then LB 0x13 and LBU 0x13 → word 4 = 0x80xxxxxx with other lanes unchanged; LB=0xFFFFFF80, LBU=0x00000080.
4. LW addr 0x06 → out_misalign=1, out_lmd=0, no stall, RAM unchanged. ADD (opcode 0) with alu 0x1234 → out_alu=0x1234 next cycle, out_valid=1.
5. W=0 back-to-back SW/LW/ADD → one result per cycle, stall never asserted. Address 0x400 (DEPTH=256) aliases word 0.
6. Reset asserted during BUSY of SW 0x20 = 0x55 → stall drops immediately; disp_addr=8 shows the old value.
